// File: rtl/uart_transmitter_controller_if.sv
// Response/FIFO-side bundle of the UART transmitter controller.
// The controller takes the slave view: it consumes responses and drives the TX FIFO write port.
interface uart_transmitter_controller_if #(
   parameter int DATA_WIDTH = 8
);
   logic                      enable;
   logic [DATA_WIDTH-1:0]     read_data;
   logic                      read_data_valid;
   logic [2*DATA_WIDTH-1:0]   ALU_result;
   logic                      ALU_result_valid;
   logic                      FIFO_full;
   logic [DATA_WIDTH-1:0]     FIFO_write_data;
   logic                      FIFO_write_enable;
   logic                      busy;

   // Response source / FIFO model side
   modport master (
      output enable, read_data, read_data_valid, ALU_result, ALU_result_valid, FIFO_full,
      input  FIFO_write_data, FIFO_write_enable, busy
   );

   // Controller side
   modport slave (
      input  enable, read_data, read_data_valid, ALU_result, ALU_result_valid, FIFO_full,
      output FIFO_write_data, FIFO_write_enable, busy
   );
endinterface

// File: rtl/uart_transmitter_controller.sv
// UART transmitter controller: captures one register-file read byte or one two-byte
// ALU result and writes it into the TX FIFO one byte per cycle, LSB first, stalling
// on FIFO_full without ever dropping or repeating a byte.
module uart_transmitter_controller #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   uart_transmitter_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      SEND_READ    = 2'd1,
      SEND_ALU_LSB = 2'd2,
      SEND_ALU_MSB = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [2*DATA_WIDTH-1:0]   capture_q, capture_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      wen_q, wen_d;

   // Next-state, capture and FIFO write decode
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d   = state_q;
      capture_d = capture_q;
      wdata_d   = wdata_q;
      wen_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.enable && bus.read_data_valid) begin
               // Read data has priority; a simultaneous ALU pulse is dropped.
               capture_d = {{DATA_WIDTH{1'b0}}, bus.read_data};
               state_d   = SEND_READ;
            end else if (bus.enable && bus.ALU_result_valid) begin
               capture_d = bus.ALU_result;
               state_d   = SEND_ALU_LSB;
            end
         end
         SEND_READ: begin
            if (!bus.FIFO_full) begin
               wdata_d = capture_q[DATA_WIDTH-1:0];
               wen_d   = 1'b1;
               state_d = IDLE;
            end
         end
         SEND_ALU_LSB: begin
            if (!bus.FIFO_full) begin
               wdata_d = capture_q[DATA_WIDTH-1:0];
               wen_d   = 1'b1;
               state_d = SEND_ALU_MSB;
            end
         end
         SEND_ALU_MSB: begin
            if (!bus.FIFO_full) begin
               wdata_d = capture_q[2*DATA_WIDTH-1:DATA_WIDTH];
               wen_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, capture register and registered FIFO write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the capture register is reset too, so no stale ALU half can ever leak out after reset.
         state_q   <= IDLE;
         capture_q <= '0;
         wdata_q   <= '0;
         wen_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         capture_q <= capture_d;
         wdata_q   <= wdata_d;
         wen_q     <= wen_d;
      end
   end

   assign bus.FIFO_write_data   = wdata_q;
   assign bus.FIFO_write_enable = wen_q;
   assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Bench for uart_transmitter_controller: directed response pulses push expected bytes
// into a queue; a negedge monitor pops and compares on every FIFO write strobe.
module tb_uart_transmitter_controller;

   localparam int DW = 8;

   logic clk;
   logic reset;

   uart_transmitter_controller_if #(.DATA_WIDTH(DW)) bus ();

   uart_transmitter_controller #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks     = 0;
   int          errors     = 0;
   int          strobe_cnt = 0;
   logic [7:0]  exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected byte.
   always @(negedge clk) begin
      if (reset && bus.FIFO_write_enable === 1'b1) begin
         strobe_cnt++;
         if (exp_q.size() == 0)
            check("unexpected_strobe", {8'h00, bus.FIFO_write_data}, 16'hFFFF);
         else
            check("fifo_byte", {8'h00, bus.FIFO_write_data}, {8'h00, exp_q.pop_front()});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a rising edge; leaves the pulse sampled by exactly one edge.
   task automatic pulse(input logic rd_v, input logic [7:0] rd, input logic alu_v, input logic [15:0] alu);
      bus.read_data        = rd;
      bus.read_data_valid  = rd_v;
      bus.ALU_result       = alu;
      bus.ALU_result_valid = alu_v;
      tick(1);
      bus.read_data_valid  = 1'b0;
      bus.ALU_result_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      check(name, 16'(exp_q.size()), 16'd0);
   endtask

   int base;

   initial begin
      reset                = 1'b0;
      bus.enable           = 1'b1;
      bus.read_data        = '0;
      bus.read_data_valid  = 1'b0;
      bus.ALU_result       = '0;
      bus.ALU_result_valid = 1'b0;
      bus.FIFO_full        = 1'b0;
      tick(2);
      check("rst_wen",  {15'd0, bus.FIFO_write_enable}, 16'd0);
      check("rst_data", {8'd0, bus.FIFO_write_data}, 16'd0);
      check("rst_busy", {15'd0, bus.busy}, 16'd0);
      reset = 1'b1;
      tick(2);

      // 1: single read byte, strobe one cycle after capture, busy for one cycle
      exp_q.push_back(8'h5A);
      pulse(1'b1, 8'h5A, 1'b0, 16'h0);
      check("t1_busy",  {15'd0, bus.busy}, 16'd1);
      check("t1_nowen", {15'd0, bus.FIFO_write_enable}, 16'd0);
      tick(1);
      check("t1_wen",   {15'd0, bus.FIFO_write_enable}, 16'd1);
      check("t1_data",  {8'd0, bus.FIFO_write_data}, 16'h005A);
      check("t1_idle",  {15'd0, bus.busy}, 16'd0);
      tick(1);
      check("t1_wen_low", {15'd0, bus.FIFO_write_enable}, 16'd0);
      check("t1_hold",  {8'd0, bus.FIFO_write_data}, 16'h005A);
      drain("t1_drain");

      // 2: ALU result, LSB then MSB on consecutive cycles
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      pulse(1'b0, 8'h0, 1'b1, 16'hBEEF);
      check("t2_busy", {15'd0, bus.busy}, 16'd1);
      tick(1);
      check("t2_lsb",  {7'd0, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'h01EF);
      tick(1);
      check("t2_msb",  {7'd0, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'h01BE);
      tick(1);
      check("t2_done", {14'd0, bus.busy, bus.FIFO_write_enable}, 16'd0);
      drain("t2_drain");

      // 3: FIFO_full stalls before LSB and again between LSB and MSB
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      pulse(1'b0, 8'h0, 1'b1, 16'h1234);
      bus.FIFO_full = 1'b1;
      base = strobe_cnt;
      tick(5);
      check("t3_stall_lsb", 16'(strobe_cnt - base), 16'd0);
      check("t3_busy", {15'd0, bus.busy}, 16'd1);
      bus.FIFO_full = 1'b0;
      tick(1);
      check("t3_lsb", {7'd0, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'h0134);
      bus.FIFO_full = 1'b1;
      tick(3);
      check("t3_stall_msb", 16'(strobe_cnt - base), 16'd1);
      bus.FIFO_full = 1'b0;
      tick(1);
      check("t3_msb", {7'd0, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'h0112);
      tick(3);
      check("t3_total", 16'(strobe_cnt - base), 16'd2);
      drain("t3_drain");

      // 4: simultaneous valids (read wins), then ALU pulse while busy is ignored
      exp_q.push_back(8'hA1);
      base = strobe_cnt;
      pulse(1'b1, 8'hA1, 1'b1, 16'h0F0F);
      pulse(1'b0, 8'h0, 1'b1, 16'h0F0F);
      tick(5);
      check("t4_total", 16'(strobe_cnt - base), 16'd1);
      check("t4_idle",  {15'd0, bus.busy}, 16'd0);
      drain("t4_drain");

      // 5: enable low blocks capture; enable high accepts
      bus.enable = 1'b0;
      base = strobe_cnt;
      pulse(1'b1, 8'h77, 1'b0, 16'h0);
      check("t5_busy_off", {15'd0, bus.busy}, 16'd0);
      tick(3);
      check("t5_no_strobe", 16'(strobe_cnt - base), 16'd0);
      bus.enable = 1'b1;
      exp_q.push_back(8'h77);
      pulse(1'b1, 8'h77, 1'b0, 16'h0);
      tick(1);
      check("t5_data", {7'd0, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'h0177);
      drain("t5_drain");

      // 6: reset in SEND_ALU_MSB discards the MSB
      exp_q.push_back(8'hBB);
      pulse(1'b0, 8'h0, 1'b1, 16'hAABB);
      tick(1);
      bus.FIFO_full = 1'b1;
      tick(2);
      check("t6_stalled", {15'd0, bus.busy}, 16'd1);
      reset = 1'b0;
      #1;
      check("t6_rst_out", {6'd0, bus.busy, bus.FIFO_write_enable, bus.FIFO_write_data}, 16'd0);
      tick(2);
      bus.FIFO_full = 1'b0;
      reset = 1'b1;
      base = strobe_cnt;
      tick(4);
      check("t6_no_msb", 16'(strobe_cnt - base), 16'd0);
      exp_q.push_back(8'hC3);
      pulse(1'b1, 8'hC3, 1'b0, 16'h0);
      tick(4);
      check("t6_single", 16'(strobe_cnt - base), 16'd1);
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
